// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_if_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZERO_WORD        = '0;
  localparam inst_addr_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic       BRANCH_ENABLE    = 1'b1;

  typedef enum logic {
    IF_FETCH,
    IF_HOLD
  } if_state_e;

  function automatic inst_addr_t align_word(input inst_addr_t addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_if.sv
// Instruction fetch: assembles a 32-bit little-endian word from four byte
// reads through the shared memory arbiter and hands it to if_id.
module stage_if
  import stage_if_pkg::*;
#(
  parameter inst_addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_addr_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_byte_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  if_state_e  state;
  inst_addr_t pc;
  logic [2:0] issue_cnt;
  logic [2:0] recv_cnt;
  logic       pend;
  logic [7:0] lane0, lane1, lane2;

  logic granted;
  logic redirect;
  logic accept;

  assign mem_req_o  = !rst && rdy && (state == IF_FETCH) && (issue_cnt < 3'd4);
  assign mem_addr_o = pc + {29'b0, issue_cnt};
  assign granted    = mem_req_o && mem_grant_i;
  assign redirect   = (branch_enable_i == BRANCH_ENABLE) && !stall_i;
  assign accept     = inst_valid_o && !stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IF_FETCH;
      pc           <= RESET_PC;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      pend         <= 1'b0;
      lane0        <= '0;
      lane1        <= '0;
      lane2        <= '0;
      pc_o         <= '0;
      inst_o       <= ZERO_WORD;
      inst_valid_o <= 1'b0;
    end else if (rdy) begin
      if (redirect) begin
        // Clearing pend drops the byte still in flight from this cycle's grant.
        state        <= IF_FETCH;
        pc           <= align_word(branch_addr_i);
        issue_cnt    <= '0;
        recv_cnt     <= '0;
        pend         <= 1'b0;
        pc_o         <= '0;
        inst_o       <= ZERO_WORD;
        inst_valid_o <= 1'b0;
      end else begin
        case (state)
          IF_FETCH: begin
            pend <= granted;
            if (granted) issue_cnt <= issue_cnt + 3'd1;
            if (pend) begin
              recv_cnt <= recv_cnt + 3'd1;
              case (recv_cnt[1:0])
                2'd0: lane0 <= mem_byte_i;
                2'd1: lane1 <= mem_byte_i;
                2'd2: lane2 <= mem_byte_i;
                default: begin
                  // Byte 3 goes straight into the output word; no lane needed.
                  inst_o       <= {mem_byte_i, lane2, lane1, lane0};
                  pc_o         <= pc;
                  inst_valid_o <= 1'b1;
                  state        <= IF_HOLD;
                end
              endcase
            end
          end
          IF_HOLD: begin
            pend <= 1'b0;
            if (accept) begin
              pc           <= pc + 32'd4;
              issue_cnt    <= '0;
              recv_cnt     <= '0;
              inst_valid_o <= 1'b0;
              state        <= IF_FETCH;
            end
          end
          default: state <= IF_FETCH;
        endcase
      end
    end
  end

endmodule
